// File: rtl/axi_slave_rw_scheduler.sv
// rtl/axi_slave_rw_scheduler.sv - round-robin write/read scheduler for the AXI slave FIFO front end
//
// Takes the front end's pending write/read requests, grants one at a time
// (ties alternate, first tie after reset goes to write), and runs the granted
// transaction over a single backend port: command handshake, then either a
// write-data passthrough from the receive buffer or a read-data capture into
// the send buffer. Only one backend transaction is in flight at any time.
//
// Ports:
//   ACLK, ARESETn                    clock, asynchronous active-low reset
//   IssueWrite/IssueRead             pending requests from the front end
//   Got_IssueWrite/Got_IssueRead     one-cycle registered grant pulses
//   SLAVE_WADDRREG/AWLEN/AWID        write request fields
//   SLAVE_RADDRREG/ARLEN/ARID        read request fields
//   SLAVE_WDATAREG/SLAVE_WVALID      receive-buffer head (show-ahead)
//   S_INPUT_RE                       receive-buffer dequeue
//   SLAVE_RDATAREG/S_INPUT_WE        send-buffer enqueue data/strobe
//   STOP_WREQ                        block new AW/AR acceptance
//   BE_THROTTLE                      backend congestion
//   BE_CMD_*                         backend command channel
//   BE_WDATA/WVALID/WLAST/WREADY     backend write-data channel
//   BE_RDATA/RVALID/RREADY           backend read-data channel
module axi_slave_rw_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  IssueWrite,
    input  logic                  IssueRead,
    output logic                  Got_IssueWrite,
    output logic                  Got_IssueRead,
    input  logic [ADDR_WIDTH-1:0] SLAVE_WADDRREG,
    input  logic [LEN_WIDTH-1:0]  SLAVE_AWLEN,
    input  logic [ID_WIDTH-1:0]   SLAVE_AWID,
    input  logic [ADDR_WIDTH-1:0] SLAVE_RADDRREG,
    input  logic [LEN_WIDTH-1:0]  SLAVE_ARLEN,
    input  logic [ID_WIDTH-1:0]   SLAVE_ARID,
    input  logic [DATA_WIDTH-1:0] SLAVE_WDATAREG,
    input  logic                  SLAVE_WVALID,
    output logic                  S_INPUT_RE,
    output logic [DATA_WIDTH-1:0] SLAVE_RDATAREG,
    output logic                  S_INPUT_WE,
    output logic                  STOP_WREQ,
    input  logic                  BE_THROTTLE,
    output logic                  BE_CMD_VALID,
    input  logic                  BE_CMD_READY,
    output logic                  BE_CMD_WRITE,
    output logic [ADDR_WIDTH-1:0] BE_CMD_ADDR,
    output logic [LEN_WIDTH-1:0]  BE_CMD_LEN,
    output logic [ID_WIDTH-1:0]   BE_CMD_ID,
    output logic [DATA_WIDTH-1:0] BE_WDATA,
    output logic                  BE_WVALID,
    output logic                  BE_WLAST,
    input  logic                  BE_WREADY,
    input  logic [DATA_WIDTH-1:0] BE_RDATA,
    input  logic                  BE_RVALID,
    output logic                  BE_RREADY
);

    // One extra bit so a full-length burst (LEN all ones) still fits LEN+1.
    localparam int CNT_WIDTH = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_CMD,
        S_W_DATA,
        S_R_CMD,
        S_R_DATA
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_write_q, last_grant_write_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  got_write_q, got_write_d;
    logic                  got_read_q, got_read_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_WIDTH-1:0]  cmd_len_q, cmd_len_d;
    logic [ID_WIDTH-1:0]   cmd_id_q, cmd_id_d;
    logic                  send_we_q, send_we_d;
    logic [DATA_WIDTH-1:0] send_data_q, send_data_d;
    logic                  stop_wreq_q, stop_wreq_d;

    logic in_w_data;
    logic in_r_data;
    logic w_beat_valid;
    logic w_beat_fire;
    logic r_beat_fire;
    logic last_beat;
    logic grant_write;

    assign in_w_data    = (state_q == S_W_DATA);
    assign in_r_data    = (state_q == S_R_DATA);
    assign w_beat_valid = in_w_data & SLAVE_WVALID;
    assign w_beat_fire  = w_beat_valid & BE_WREADY;
    assign r_beat_fire  = in_r_data & BE_RVALID;
    assign last_beat    = (beat_cnt_q == CNT_WIDTH'(1));

    // Write wins when it is the only request, or on a tie when the previous
    // grant was a read.
    assign grant_write  = IssueWrite & (~IssueRead | ~last_grant_write_q);

    always_comb begin
        state_d            = state_q;
        last_grant_write_d = last_grant_write_q;
        beat_cnt_d         = beat_cnt_q;
        got_write_d        = 1'b0;
        got_read_d         = 1'b0;
        cmd_write_d        = cmd_write_q;
        cmd_addr_d         = cmd_addr_q;
        cmd_len_d          = cmd_len_q;
        cmd_id_d           = cmd_id_q;
        send_we_d          = 1'b0;
        send_data_d        = send_data_q;

        case (state_q)
            S_IDLE: begin
                if (IssueWrite | IssueRead) begin
                    last_grant_write_d = grant_write;
                    cmd_write_d        = grant_write;
                    if (grant_write) begin
                        got_write_d = 1'b1;
                        cmd_addr_d  = SLAVE_WADDRREG;
                        cmd_len_d   = SLAVE_AWLEN;
                        cmd_id_d    = SLAVE_AWID;
                        beat_cnt_d  = {1'b0, SLAVE_AWLEN} + CNT_WIDTH'(1);
                        state_d     = S_W_CMD;
                    end else begin
                        got_read_d  = 1'b1;
                        cmd_addr_d  = SLAVE_RADDRREG;
                        cmd_len_d   = SLAVE_ARLEN;
                        cmd_id_d    = SLAVE_ARID;
                        beat_cnt_d  = {1'b0, SLAVE_ARLEN} + CNT_WIDTH'(1);
                        state_d     = S_R_CMD;
                    end
                end
            end
            // BE_CMD_VALID is high for the whole command state, so READY alone
            // completes the handshake.
            S_W_CMD: begin
                if (BE_CMD_READY) begin
                    state_d = S_W_DATA;
                end
            end
            S_R_CMD: begin
                if (BE_CMD_READY) begin
                    state_d = S_R_DATA;
                end
            end
            S_W_DATA: begin
                if (w_beat_fire) begin
                    beat_cnt_d = beat_cnt_q - CNT_WIDTH'(1);
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            // The send buffer is deep enough for a maximum burst, so every
            // backend beat is taken without backpressure.
            S_R_DATA: begin
                if (r_beat_fire) begin
                    send_we_d   = 1'b1;
                    send_data_d = BE_RDATA;
                    beat_cnt_d  = beat_cnt_q - CNT_WIDTH'(1);
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_valid_d = (state_d == S_W_CMD) || (state_d == S_R_CMD);
    end

    // Holding off new AW/AR while both request slots are occupied and a
    // transaction is running keeps a third request from arriving.
    assign stop_wreq_d = BE_THROTTLE | ((state_q != S_IDLE) & IssueWrite & IssueRead);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q            <= S_IDLE;
            last_grant_write_q <= 1'b0;
            beat_cnt_q         <= '0;
            got_write_q        <= 1'b0;
            got_read_q         <= 1'b0;
            cmd_valid_q        <= 1'b0;
            cmd_write_q        <= 1'b0;
            cmd_addr_q         <= '0;
            cmd_len_q          <= '0;
            cmd_id_q           <= '0;
            send_we_q          <= 1'b0;
            send_data_q        <= '0;
            stop_wreq_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            last_grant_write_q <= last_grant_write_d;
            beat_cnt_q         <= beat_cnt_d;
            got_write_q        <= got_write_d;
            got_read_q         <= got_read_d;
            cmd_valid_q        <= cmd_valid_d;
            cmd_write_q        <= cmd_write_d;
            cmd_addr_q         <= cmd_addr_d;
            cmd_len_q          <= cmd_len_d;
            cmd_id_q           <= cmd_id_d;
            send_we_q          <= send_we_d;
            send_data_q        <= send_data_d;
            stop_wreq_q        <= stop_wreq_d;
        end
    end

    assign Got_IssueWrite = got_write_q;
    assign Got_IssueRead  = got_read_q;
    assign BE_CMD_VALID   = cmd_valid_q;
    assign BE_CMD_WRITE   = cmd_write_q;
    assign BE_CMD_ADDR    = cmd_addr_q;
    assign BE_CMD_LEN     = cmd_len_q;
    assign BE_CMD_ID      = cmd_id_q;
    assign S_INPUT_WE     = send_we_q;
    assign SLAVE_RDATAREG = send_data_q;
    assign STOP_WREQ      = stop_wreq_q;

    // Write data flows straight from the receive-buffer head to the backend.
    assign BE_WDATA       = in_w_data ? SLAVE_WDATAREG : '0;
    assign BE_WVALID      = w_beat_valid;
    assign BE_WLAST       = w_beat_valid & last_beat;
    assign S_INPUT_RE     = w_beat_fire;
    assign BE_RREADY      = in_r_data;

endmodule

// File: tb/tb_axi_slave_rw_scheduler.sv
// tb/tb_axi_slave_rw_scheduler.sv - randomized and directed bench for axi_slave_rw_scheduler
module tb_axi_slave_rw_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic        IssueWrite = 1'b0, IssueRead = 1'b0;
    logic        Got_IssueWrite, Got_IssueRead;
    logic [31:0] SLAVE_WADDRREG = '0, SLAVE_RADDRREG = '0;
    logic [3:0]  SLAVE_AWLEN = '0, SLAVE_AWID = '0, SLAVE_ARLEN = '0, SLAVE_ARID = '0;
    logic [31:0] SLAVE_WDATAREG = '0;
    logic        SLAVE_WVALID = 1'b0;
    logic        S_INPUT_RE;
    logic [31:0] SLAVE_RDATAREG;
    logic        S_INPUT_WE, STOP_WREQ;
    logic        BE_THROTTLE = 1'b0;
    logic        BE_CMD_VALID;
    logic        BE_CMD_READY = 1'b0;
    logic        BE_CMD_WRITE;
    logic [31:0] BE_CMD_ADDR;
    logic [3:0]  BE_CMD_LEN, BE_CMD_ID;
    logic [31:0] BE_WDATA;
    logic        BE_WVALID, BE_WLAST;
    logic        BE_WREADY = 1'b0;
    logic [31:0] BE_RDATA = '0;
    logic        BE_RVALID = 1'b0;
    logic        BE_RREADY;

    always #5 ACLK = ~ACLK;

    axi_slave_rw_scheduler #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .IssueWrite(IssueWrite), .IssueRead(IssueRead),
        .Got_IssueWrite(Got_IssueWrite), .Got_IssueRead(Got_IssueRead),
        .SLAVE_WADDRREG(SLAVE_WADDRREG), .SLAVE_AWLEN(SLAVE_AWLEN), .SLAVE_AWID(SLAVE_AWID),
        .SLAVE_RADDRREG(SLAVE_RADDRREG), .SLAVE_ARLEN(SLAVE_ARLEN), .SLAVE_ARID(SLAVE_ARID),
        .SLAVE_WDATAREG(SLAVE_WDATAREG), .SLAVE_WVALID(SLAVE_WVALID), .S_INPUT_RE(S_INPUT_RE),
        .SLAVE_RDATAREG(SLAVE_RDATAREG), .S_INPUT_WE(S_INPUT_WE), .STOP_WREQ(STOP_WREQ),
        .BE_THROTTLE(BE_THROTTLE), .BE_CMD_VALID(BE_CMD_VALID), .BE_CMD_READY(BE_CMD_READY),
        .BE_CMD_WRITE(BE_CMD_WRITE), .BE_CMD_ADDR(BE_CMD_ADDR), .BE_CMD_LEN(BE_CMD_LEN),
        .BE_CMD_ID(BE_CMD_ID), .BE_WDATA(BE_WDATA), .BE_WVALID(BE_WVALID), .BE_WLAST(BE_WLAST),
        .BE_WREADY(BE_WREADY), .BE_RDATA(BE_RDATA), .BE_RVALID(BE_RVALID), .BE_RREADY(BE_RREADY)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: which transaction is active, how far along it is,
    // and what registered outputs must show in the coming cycle.
    typedef enum int {M_IDLE, M_CMD, M_DATA} mphase_t;
    mphase_t     m_phase;
    bit          m_write, m_last_was_write;
    int          m_left;
    logic [31:0] m_addr, m_rdata;
    logic [3:0]  m_len, m_id;
    bit          m_got_w, m_got_r, m_we, m_stop;

    // Front-end request slots and stimulus knobs.
    bit          pend_w, pend_r, cool_w, cool_r;
    logic [31:0] pw_addr, pr_addr;
    logic [3:0]  pw_len, pw_id, pr_len, pr_id;
    bit          rnd_mode;
    int          posts_w, posts_r;
    logic [3:0]  fx_awlen, fx_arlen;
    bit          fx_cmd_ready, fx_wready, fx_wvalid, fx_rvalid;

    // Observations of DUT activity used for literal expectations.
    int          obs_re, obs_we, obs_wlast, obs_cmd_wait, grant_n;
    logic [7:0]  grant_log;
    bit          pin_w;

    task automatic model_reset();
        m_phase = M_IDLE; m_write = 0; m_last_was_write = 0; m_left = 0;
        m_addr = '0; m_len = '0; m_id = '0; m_rdata = '0;
        m_got_w = 0; m_got_r = 0; m_we = 0; m_stop = 0;
        pend_w = 0; pend_r = 0; cool_w = 0; cool_r = 0;
        IssueWrite = 0; IssueRead = 0;
    endtask

    task automatic gen_inputs();
        if (!pend_w && !cool_w && (rnd_mode ? ($urandom_range(3) == 0) : (posts_w > 0))) begin
            pend_w = 1;
            if (!rnd_mode) posts_w--;
            pw_addr = rnd_mode ? $urandom : 32'h1000_0040;
            pw_len  = rnd_mode ? 4'($urandom_range(15)) : fx_awlen;
            pw_id   = 4'($urandom_range(15));
        end
        if (!pend_r && !cool_r && (rnd_mode ? ($urandom_range(3) == 0) : (posts_r > 0))) begin
            pend_r = 1;
            if (!rnd_mode) posts_r--;
            pr_addr = rnd_mode ? $urandom : 32'h2000_0080;
            pr_len  = rnd_mode ? 4'($urandom_range(15)) : fx_arlen;
            pr_id   = 4'($urandom_range(15));
        end
        cool_w = 0;
        cool_r = 0;
        IssueWrite = pend_w; SLAVE_WADDRREG = pw_addr; SLAVE_AWLEN = pw_len; SLAVE_AWID = pw_id;
        IssueRead  = pend_r; SLAVE_RADDRREG = pr_addr; SLAVE_ARLEN = pr_len; SLAVE_ARID = pr_id;
        if (rnd_mode) begin
            BE_CMD_READY = ($urandom_range(2) != 0);
            BE_WREADY    = ($urandom_range(3) != 0);
            SLAVE_WVALID = ($urandom_range(2) != 0);
            BE_RVALID    = ($urandom_range(2) != 0);
            BE_THROTTLE  = ($urandom_range(7) == 0);
        end else begin
            BE_CMD_READY = fx_cmd_ready;
            BE_WREADY    = fx_wready;
            SLAVE_WVALID = fx_wvalid;
            BE_RVALID    = fx_rvalid;
            BE_THROTTLE  = 1'b0;
        end
        SLAVE_WDATAREG = $urandom;
        BE_RDATA       = $urandom;
    endtask

    task automatic check_outputs();
        bit ew;
        ew = (m_phase == M_DATA && m_write) ? SLAVE_WVALID : 1'b0;
        chk("got_write", 32'(Got_IssueWrite), 32'(m_got_w));
        chk("got_read", 32'(Got_IssueRead), 32'(m_got_r));
        chk("cmd_valid", 32'(BE_CMD_VALID), 32'(m_phase == M_CMD));
        if (m_phase != M_IDLE) begin
            chk("cmd_write", 32'(BE_CMD_WRITE), 32'(m_write));
            chk("cmd_addr", BE_CMD_ADDR, m_addr);
            chk("cmd_len", 32'(BE_CMD_LEN), 32'(m_len));
            chk("cmd_id", 32'(BE_CMD_ID), 32'(m_id));
        end
        chk("wvalid", 32'(BE_WVALID), 32'(ew));
        chk("wlast", 32'(BE_WLAST), 32'(ew && m_left == 1));
        chk("input_re", 32'(S_INPUT_RE), 32'(ew && BE_WREADY));
        if (ew) chk("wdata", BE_WDATA, SLAVE_WDATAREG);
        chk("rready", 32'(BE_RREADY), 32'(m_phase == M_DATA && !m_write));
        chk("input_we", 32'(S_INPUT_WE), 32'(m_we));
        if (m_we) chk("rdata", SLAVE_RDATAREG, m_rdata);
        chk("stop_wreq", 32'(STOP_WREQ), 32'(m_stop));
    endtask

    task automatic observe();
        if (Got_IssueWrite) begin grant_log = {grant_log[6:0], 1'b1}; grant_n++; end
        if (Got_IssueRead)  begin grant_log = {grant_log[6:0], 1'b0}; grant_n++; end
        if (S_INPUT_RE) obs_re++;
        if (S_INPUT_WE) obs_we++;
        if (BE_WLAST) obs_wlast++;
        if (BE_CMD_VALID && !BE_CMD_READY) obs_cmd_wait++;
        if (pin_w && Got_IssueWrite) begin
            chk("first_w_addr", BE_CMD_ADDR, 32'h1000_0040);
            chk("first_w_len", 32'(BE_CMD_LEN), 32'd3);
            pin_w = 0;
        end
    endtask

    task automatic model_advance();
        bit gw, n_got_w, n_got_r, n_we, drop_w, drop_r;
        n_got_w = 0; n_got_r = 0; n_we = 0;
        drop_w = m_got_w; drop_r = m_got_r;
        m_stop = BE_THROTTLE || (m_phase != M_IDLE && IssueWrite && IssueRead);
        case (m_phase)
            M_IDLE: if (IssueWrite || IssueRead) begin
                gw = IssueWrite && !(IssueRead && m_last_was_write);
                m_write = gw; m_last_was_write = gw;
                if (gw) begin m_addr = pw_addr; m_len = pw_len; m_id = pw_id; n_got_w = 1; end
                else    begin m_addr = pr_addr; m_len = pr_len; m_id = pr_id; n_got_r = 1; end
                m_left = int'(m_len) + 1;
                m_phase = M_CMD;
            end
            M_CMD: if (BE_CMD_READY) m_phase = M_DATA;
            default: begin
                if (m_write) begin
                    if (SLAVE_WVALID && BE_WREADY) m_left--;
                end else if (BE_RVALID) begin
                    n_we = 1; m_rdata = BE_RDATA; m_left--;
                end
                if (m_left == 0) m_phase = M_IDLE;
            end
        endcase
        m_got_w = n_got_w; m_got_r = n_got_r; m_we = n_we;
        if (drop_w) begin pend_w = 0; cool_w = 1; end
        if (drop_r) begin pend_r = 0; cool_r = 1; end
    endtask

    task automatic step();
        @(negedge ACLK);
        gen_inputs();
        #1;
        check_outputs();
        observe();
        model_advance();
    endtask

    function automatic bit quiet();
        return m_phase == M_IDLE && !pend_w && !pend_r && posts_w == 0 && posts_r == 0 && !m_we;
    endfunction

    task automatic run_until_quiet(input string name, input int budget);
        int n = 0;
        while (!quiet() && n < budget) begin step(); n++; end
        chk(name, 32'(quiet()), 32'd1);
    endtask

    task automatic clear_obs();
        obs_re = 0; obs_we = 0; obs_wlast = 0; obs_cmd_wait = 0; grant_n = 0; grant_log = '0;
    endtask

    task automatic apply_reset();
        ARESETn = 0;
        #1;
        chk("rst_got_w", 32'(Got_IssueWrite), 32'd0);
        chk("rst_got_r", 32'(Got_IssueRead), 32'd0);
        chk("rst_cmd_valid", 32'(BE_CMD_VALID), 32'd0);
        chk("rst_cmd_addr", BE_CMD_ADDR, 32'd0);
        chk("rst_re", 32'(S_INPUT_RE), 32'd0);
        chk("rst_we", 32'(S_INPUT_WE), 32'd0);
        chk("rst_rready", 32'(BE_RREADY), 32'd0);
        chk("rst_wvalid", 32'(BE_WVALID), 32'd0);
        chk("rst_stop", 32'(STOP_WREQ), 32'd0);
        chk("rst_rdata", SLAVE_RDATAREG, 32'd0);
        model_reset();
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1;
    endtask

    initial begin
        rnd_mode = 0; posts_w = 0; posts_r = 0; pin_w = 0;
        fx_awlen = 0; fx_arlen = 0;
        fx_cmd_ready = 1; fx_wready = 1; fx_wvalid = 1; fx_rvalid = 1;
        pw_addr = '0; pr_addr = '0; pw_len = '0; pr_len = '0; pw_id = '0; pr_id = '0;
        clear_obs();
        #2;
        apply_reset();

        // Ties from reset: write first, then alternating; extra read beats ignored.
        fx_awlen = 4'd3; fx_arlen = 4'd15; posts_w = 2; posts_r = 2; pin_w = 1;
        clear_obs();
        run_until_quiet("ties_done", 300);
        for (int i = 0; i < 3; i++) step();
        chk("tie_grant_count", 32'(grant_n), 32'd4);
        chk("tie_grant_order", 32'(grant_log[3:0]), 32'b1010);
        chk("tie_re_pulses", 32'(obs_re), 32'd8);
        chk("tie_we_pulses", 32'(obs_we), 32'd32);
        chk("tie_wlast_count", 32'(obs_wlast), 32'd2);

        // Command held off for 10 cycles.
        fx_cmd_ready = 0; fx_awlen = 4'd0; posts_w = 1;
        for (int n = 0; n < 20 && m_phase != M_CMD; n++) step();
        clear_obs();
        for (int i = 0; i < 10; i++) step();
        chk("cmd_wait_cycles", 32'(obs_cmd_wait), 32'd10);
        chk("cmd_wait_no_re", 32'(obs_re), 32'd0);
        fx_cmd_ready = 1;
        run_until_quiet("cmd_wait_done", 50);

        // Gappy receive buffer on a 2-beat write.
        fx_wvalid = 0; fx_awlen = 4'd1; posts_w = 1;
        for (int n = 0; n < 20 && m_phase != M_DATA; n++) step();
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            fx_wvalid = (i == 0 || i == 3);
            step();
        end
        chk("gap_re_pulses", 32'(obs_re), 32'd2);
        chk("gap_wlast_count", 32'(obs_wlast), 32'd1);
        fx_wvalid = 1;
        run_until_quiet("gap_done", 20);

        // Reset in the middle of an 8-beat read, then a single-beat read.
        fx_arlen = 4'd7; posts_r = 1;
        clear_obs();
        for (int n = 0; n < 40 && obs_we < 3; n++) step();
        chk("mid_read_beats", 32'(obs_we), 32'd3);
        apply_reset();
        fx_arlen = 4'd0; posts_r = 1;
        clear_obs();
        run_until_quiet("post_reset_done", 40);
        for (int i = 0; i < 3; i++) step();
        chk("post_reset_we", 32'(obs_we), 32'd1);

        // Randomized traffic against the model.
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        rnd_mode = 0;
        fx_cmd_ready = 1; fx_wready = 1; fx_wvalid = 1; fx_rvalid = 1;
        run_until_quiet("drain_done", 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
